ct_spsram_param_init: RTL and testbench

//   Parametrised single-port SRAM for the FPGA memory path: configurable depth/width, bit-granular active-low

---
 rtl/ct_spsram_param_init.sv | 135 +++++++++++++
 tb/tb_ct_spsram_param_init.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ct_spsram_param_init.sv
// Parametrised single-port SRAM with a bit-granular active-low write mask, an optional output register,
// and a sequencer that fills every entry with INIT_VALUE after reset or on request.
module ct_spsram_param_init #(
    parameter int                    DEPTH      = 2048,
    parameter int                    ADDR_WIDTH = 11,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  INIT_REQ,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  INIT_BUSY,
    output logic                  dbg_state_o
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_IDLE = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    busy;
    logic                    in_range;
    logic                    acc_wr;
    logic                    rd_en;
    logic                    port_we;
    logic [ADDR_WIDTH-1:0]   port_addr;
    logic [DATA_WIDTH-1:0]   port_wdata;
    logic [DATA_WIDTH-1:0]   port_bwe;
    logic [DATA_WIDTH-1:0]   rd_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign busy        = (state_q == S_INIT);
    assign INIT_BUSY   = busy;
    assign dbg_state_o = state_q;
    assign in_range    = ({1'b0, A} < (ADDR_WIDTH + 1)'(DEPTH));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_INIT: begin
                if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (INIT_REQ) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // The sequencer and the external port share one physical write port.
    always_comb begin
        acc_wr     = !busy && !CEN && !GWEN && in_range;
        rd_en      = !busy && !CEN && GWEN;
        port_we    = busy || acc_wr;
        port_addr  = busy ? cnt_q : A;
        port_wdata = busy ? INIT_VALUE : D;
        port_bwe   = busy ? '1 : ~WEN;
    end

    always_ff @(posedge CLK) begin
        if (port_we) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (port_bwe[i]) begin
                    mem[port_addr][i] <= port_wdata[i];
                end
            end
        end
    end

    // Out-of-range reads return zero instead of touching the array.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_q <= '0;
        end else if (rd_en) begin
            rd_q <= in_range ? mem[A] : '0;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  pend_q;
            logic [DATA_WIDTH-1:0] q_out_q;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    pend_q  <= 1'b0;
                    q_out_q <= '0;
                end else begin
                    pend_q <= rd_en;
                    if (pend_q) begin
                        q_out_q <= rd_q;
                    end
                end
            end

            assign Q = q_out_q;
        end else begin : g_no_out_reg
            assign Q = rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_ct_spsram_param_init.sv
// Directed bench for ct_spsram_param_init: three instances (default, OUT_REG=1 with non-zero
// INIT_VALUE, DEPTH=1000) share one stimulus stream.
module tb_ct_spsram_param_init;

    localparam logic [31:0] INIT1 = 32'h5A5A0F0F;

    logic        clk;
    logic        rst;
    logic [10:0] a;
    logic        cen;
    logic        gwen;
    logic [31:0] wen;
    logic [31:0] d;
    logic        init_req;
    logic [31:0] q0, q1, q2;
    logic        b0, b1, b2;
    logic        s0, s1, s2;

    int n_checks = 0;
    int n_err    = 0;

    ct_spsram_param_init #(.DEPTH(2048), .ADDR_WIDTH(11), .DATA_WIDTH(32), .OUT_REG(0),
                           .INIT_VALUE(32'h0)) dut0 (
        .CLK(clk), .RST(rst), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d),
        .INIT_REQ(init_req), .Q(q0), .INIT_BUSY(b0), .dbg_state_o(s0));

    ct_spsram_param_init #(.DEPTH(2048), .ADDR_WIDTH(11), .DATA_WIDTH(32), .OUT_REG(1),
                           .INIT_VALUE(INIT1)) dut1 (
        .CLK(clk), .RST(rst), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d),
        .INIT_REQ(init_req), .Q(q1), .INIT_BUSY(b1), .dbg_state_o(s1));

    ct_spsram_param_init #(.DEPTH(1000), .ADDR_WIDTH(10), .DATA_WIDTH(32), .OUT_REG(0),
                           .INIT_VALUE(32'h0)) dut2 (
        .CLK(clk), .RST(rst), .A(a[9:0]), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d),
        .INIT_REQ(init_req), .Q(q2), .INIT_BUSY(b2), .dbg_state_o(s2));

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [10:0] addr, input logic [31:0] data, input logic [31:0] mask_n);
        a = addr; d = data; wen = mask_n; cen = 1'b0; gwen = 1'b0;
        tick();
        cen = 1'b1; gwen = 1'b1; wen = '1;
    endtask

    task automatic rd(input logic [10:0] addr);
        a = addr; cen = 1'b0; gwen = 1'b1;
        tick();
        cen = 1'b1;
    endtask

    task automatic idle();
        cen = 1'b1;
        tick();
    endtask

    // Runs until dut0 leaves INIT; records the busy length of every instance. With noisy set, it
    // hammers the port with reads/writes to A=7 and pulses INIT_REQ once mid-init, and counts any
    // q0 movement away from hold0.
    task automatic wait_idle(input bit noisy, input logic [31:0] hold0,
                             output int n0, output int n1, output int n2, output int qbad);
        int n;
        n = 0; n0 = 0; n1 = 0; n2 = 0; qbad = 0;
        while (n < 5000 && n0 == 0) begin
            if (noisy) begin
                a = 11'd7; d = '1; wen = '0; cen = 1'b0;
                gwen = (n < 900) ? n[0] : 1'b1;
                init_req = (n == 100);
            end
            tick();
            n++;
            if (noisy && q0 !== hold0) qbad++;
            if (!b2 && n2 == 0) n2 = n;
            if (!b1 && n1 == 0) n1 = n;
            if (!b0) n0 = n;
        end
        cen = 1'b1; gwen = 1'b1; wen = '1; init_req = 1'b0;
    endtask

    initial begin
        int n0, n1, n2, qbad, bad0, bad1;

        rst = 1'b1; a = '0; cen = 1'b1; gwen = 1'b1; wen = '1; d = '0; init_req = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_q0", q0, 32'h0);
        chk("rst_q1", q1, 32'h0);
        chk("rst_busy0", {31'b0, b0}, 32'd1);
        chk("rst_busy2", {31'b0, b2}, 32'd1);
        chk("rst_state0", {31'b0, s0}, 32'd0);

        // Init fill after reset release
        rst = 1'b0;
        wait_idle(1'b0, 32'h0, n0, n1, n2, qbad);
        chk("init_len0", n0, 32'd2048);
        chk("init_len1", n1, 32'd2048);
        chk("init_len2", n2, 32'd1000);
        chk("idle_state0", {31'b0, s0}, 32'd1);

        rd(11'd0);
        chk("t1_rd0_q0", q0, 32'h0);
        chk("t1_rd0_q1_early", q1, 32'h0);
        idle();
        chk("t1_rd0_q1", q1, INIT1);
        rd(11'd1023);
        chk("t1_rd1023_q0", q0, 32'h0);
        chk("t1_rd1023_q2_oor", q2, 32'h0);
        idle();
        chk("t1_rd1023_q1", q1, INIT1);
        rd(11'd2047);
        chk("t1_rd2047_q0", q0, 32'h0);
        idle();
        chk("t1_rd2047_q1", q1, INIT1);

        // Bit mask, back-to-back read after write
        wr(11'd5, 32'hDEADBEEF, 32'hFFFF0000);
        rd(11'd5);
        chk("t2_mask_lo_q0", q0, 32'h0000BEEF);
        chk("t2_mask_lo_q2", q2, 32'h0000BEEF);
        idle();
        chk("t2_mask_lo_q1", q1, 32'h5A5ABEEF);
        wr(11'd5, 32'h12345678, 32'h0000FFFF);
        chk("t3_q1_hold_wr", q1, 32'h5A5ABEEF);
        rd(11'd5);
        chk("t2_mask_hi_q0", q0, 32'h1234BEEF);
        chk("t3_q1_lat1", q1, 32'h5A5ABEEF);
        idle();
        chk("t3_q1_lat2", q1, 32'h1234BEEF);

        // Hold across a write and idle cycles
        wr(11'd5, 32'h0, 32'h0);
        chk("t3_q0_no_wthru", q0, 32'h1234BEEF);
        chk("t3_q1_no_wthru", q1, 32'h1234BEEF);
        idle(); idle(); idle();
        chk("t3_q1_idle_hold", q1, 32'h1234BEEF);
        chk("t3_q0_idle_hold", q0, 32'h1234BEEF);
        rd(11'd5);
        chk("t3_full_wr_q0", q0, 32'h0);

        // Out of range on the 1000-entry instance
        wr(11'd1010, 32'hFFFFFFFF, 32'h0);
        rd(11'd1010);
        chk("t4_oor_q2", q2, 32'h0);
        chk("t4_inrange_q0", q0, 32'hFFFFFFFF);
        bad0 = 0;
        for (int i = 0; i < 1000; i++) begin
            a = 11'(i); cen = 1'b0; gwen = 1'b1;
            tick();
            if (q2 !== 32'h0) bad0++;
        end
        cen = 1'b1;
        chk("t4_entries_unchanged", bad0, 32'd0);

        // Re-init on request
        wr(11'd7, 32'hA5A5A5A5, 32'h0);
        rd(11'd7);
        chk("t5_pre_q0", q0, 32'hA5A5A5A5);
        a = 11'd5; cen = 1'b0; gwen = 1'b1; init_req = 1'b1;
        tick();
        init_req = 1'b0; cen = 1'b1;
        chk("t5_same_cycle_rd", q0, 32'h0);
        chk("t5_busy_start", {31'b0, b0}, 32'd1);
        wait_idle(1'b1, 32'h0, n0, n1, n2, qbad);
        chk("t5_busy_len0", n0, 32'd2048);
        chk("t5_busy_len2", n2, 32'd1000);
        chk("t5_q_hold_busy", qbad, 32'd0);
        rd(11'd7);
        chk("t5_reinit_q0", q0, 32'h0);
        idle();
        chk("t5_reinit_q1", q1, INIT1);

        // Reset in the middle of an init pass
        wr(11'd3, 32'hCAFEF00D, 32'h0);
        rd(11'd3);
        chk("t6_pre_q0", q0, 32'hCAFEF00D);
        idle();
        chk("t6_pre_q1", q1, 32'hCAFEF00D);
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        repeat (700) tick();
        chk("t6_busy_700", {31'b0, b0}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_q0", q0, 32'h0);
        chk("t6_rst_q1", q1, 32'h0);
        chk("t6_rst_busy", {31'b0, b0}, 32'd1);
        tick(); tick();
        rst = 1'b0;
        wait_idle(1'b0, 32'h0, n0, n1, n2, qbad);
        chk("t6_busy_len0", n0, 32'd2048);
        chk("t6_busy_len1", n1, 32'd2048);
        bad0 = 0; bad1 = 0;
        for (int i = 0; i <= 2048; i++) begin
            a = 11'(i); cen = (i == 2048); gwen = 1'b1;
            tick();
            if (i < 2048 && q0 !== 32'h0) bad0++;
            if (i >= 1 && q1 !== INIT1) bad1++;
        end
        cen = 1'b1;
        chk("t6_scan_q0", bad0, 32'd0);
        chk("t6_scan_q1", bad1, 32'd0);

        // Final report
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
